// File: rtl/uart_tx_framer_if.sv
// Character handshake and serial line bundle for uart_tx_framer.
// master: character source; slave: the framer.
interface uart_tx_framer_if #(
  parameter int DATA_BITS = 8
);
  logic [DATA_BITS-1:0] DataIn;
  logic                 Load;
  logic                 Ready;
  logic                 DataOut;
  logic                 Busy;
  logic                 charSent;

  modport master (
    output DataIn,
    output Load,
    input  Ready,
    input  DataOut,
    input  Busy,
    input  charSent
  );

  modport slave (
    input  DataIn,
    input  Load,
    output Ready,
    output DataOut,
    output Busy,
    output charSent
  );
endinterface

// File: rtl/uart_tx_framer.sv
// Parametrised UART transmitter: start/data/parity/stop framing.
// Ports: CLOCK_50, reset (async high), bus (slave: DataIn, Load,
// Ready, DataOut, Busy, charSent).
module uart_tx_framer #(
  parameter int CLK_DIV     = 326,
  parameter int OVERSAMPLE  = 16,
  parameter int DATA_BITS   = 8,
  parameter int PARITY_MODE = 0,
  parameter int STOP_BITS   = 1
) (
  input  logic           CLOCK_50,
  input  logic           reset,
  uart_tx_framer_if.slave bus
);

  if (DATA_BITS < 5 || DATA_BITS > 9) begin : g_bad_data
    $error("uart_tx_framer: DATA_BITS must be 5..9");
  end
  if (STOP_BITS < 1 || STOP_BITS > 2) begin : g_bad_stop
    $error("uart_tx_framer: STOP_BITS must be 1 or 2");
  end
  if (PARITY_MODE < 0 || PARITY_MODE > 2) begin : g_bad_par
    $error("uart_tx_framer: PARITY_MODE must be 0..2");
  end
  if (CLK_DIV < 1 || OVERSAMPLE < 1) begin : g_bad_div
    $error("uart_tx_framer: CLK_DIV/OVERSAMPLE must be >= 1");
  end

  localparam int DW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam int TW = (OVERSAMPLE > 1) ? $clog2(OVERSAMPLE) : 1;

  localparam logic [DW-1:0] DIV_LAST  = DW'(CLK_DIV - 1);
  localparam logic [TW-1:0] TICK_LAST = TW'(OVERSAMPLE - 1);
  localparam logic [3:0]    DATA_LAST = 4'(DATA_BITS - 1);
  localparam logic [3:0]    STOP_LAST = 4'(STOP_BITS - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_DATA,
    S_PAR,
    S_STOP
  } state_t;

  state_t               state_q, state_d;
  logic [DW-1:0]        div_q, div_d;
  logic [TW-1:0]        tick_q, tick_d;
  logic [3:0]           bit_q, bit_d;
  logic [DATA_BITS-1:0] shift_q, shift_d;
  logic                 par_q, par_d;
  logic                 dout_q, dout_d;

  logic tick;
  logic bit_end;
  logic sent;
  logic par_in;

  assign tick    = (div_q == DIV_LAST);
  assign bit_end = tick && (tick_q == TICK_LAST);
  assign par_in  = ^bus.DataIn;

  always_comb begin
    state_d = state_q;
    div_d   = div_q;
    tick_d  = tick_q;
    bit_d   = bit_q;
    shift_d = shift_q;
    par_d   = par_q;
    sent    = 1'b0;

    if (state_q != S_IDLE) begin
      div_d = tick ? '0 : div_q + 1'b1;
      if (tick) begin
        tick_d = bit_end ? '0 : tick_q + 1'b1;
      end
    end

    unique case (state_q)
      S_IDLE: begin
        if (bus.Load) begin
          state_d = S_START;
          shift_d = bus.DataIn;
          par_d   = (PARITY_MODE == 2) ? ~par_in : par_in;
          div_d   = '0;
          tick_d  = '0;
          bit_d   = '0;
        end
      end
      S_START: begin
        if (bit_end) begin
          state_d = S_DATA;
          bit_d   = '0;
        end
      end
      S_DATA: begin
        if (bit_end) begin
          shift_d = shift_q >> 1;
          if (bit_q == DATA_LAST) begin
            bit_d   = '0;
            state_d = (PARITY_MODE != 0) ? S_PAR : S_STOP;
          end else begin
            bit_d = bit_q + 1'b1;
          end
        end
      end
      S_PAR: begin
        if (bit_end) begin
          state_d = S_STOP;
          bit_d   = '0;
        end
      end
      S_STOP: begin
        if (bit_end) begin
          if (bit_q == STOP_LAST) begin
            sent    = 1'b1;
            state_d = S_IDLE;
            bit_d   = '0;
          end else begin
            bit_d = bit_q + 1'b1;
          end
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // Line level follows the next state so it changes on the
  // same edge as the state register.
  always_comb begin
    dout_d = 1'b1;
    unique case (state_d)
      S_START: dout_d = 1'b0;
      S_DATA:  dout_d = shift_d[0];
      S_PAR:   dout_d = par_q;
      default: dout_d = 1'b1;
    endcase
  end

  always_ff @(posedge CLOCK_50 or posedge reset) begin
    if (reset) begin
      state_q <= S_IDLE;
      div_q   <= '0;
      tick_q  <= '0;
      bit_q   <= '0;
      shift_q <= '0;
      par_q   <= 1'b0;
      dout_q  <= 1'b1;
    end else begin
      state_q <= state_d;
      div_q   <= div_d;
      tick_q  <= tick_d;
      bit_q   <= bit_d;
      shift_q <= shift_d;
      par_q   <= par_d;
      dout_q  <= dout_d;
    end
  end

  assign bus.Ready    = (state_q == S_IDLE);
  assign bus.Busy     = (state_q != S_IDLE);
  assign bus.charSent = sent;
  assign bus.DataOut  = dout_q;

endmodule

// File: tb/tb_uart_tx_framer.sv
// Directed bench for uart_tx_framer: 8N1, 8E1, 8O1, 7N2 frames,
// ignored loads, back-to-back, async reset mid-frame.
module tb_uart_tx_framer;

  localparam int BIT = 64;

  logic clk;
  logic rst0;
  logic rst_o;
  logic [7:0] din;
  logic [3:0] load;
  logic dout [4];
  logic rdy  [4];
  logic busy [4];
  logic sent [4];

  int n_chk;
  int n_err;

  uart_tx_framer_if #(.DATA_BITS(8)) i0 ();
  uart_tx_framer_if #(.DATA_BITS(8)) i1 ();
  uart_tx_framer_if #(.DATA_BITS(8)) i2 ();
  uart_tx_framer_if #(.DATA_BITS(7)) i3 ();

  assign i0.DataIn = din;
  assign i1.DataIn = din;
  assign i2.DataIn = din;
  assign i3.DataIn = din[6:0];
  assign i0.Load = load[0];
  assign i1.Load = load[1];
  assign i2.Load = load[2];
  assign i3.Load = load[3];

  assign dout[0] = i0.DataOut;
  assign dout[1] = i1.DataOut;
  assign dout[2] = i2.DataOut;
  assign dout[3] = i3.DataOut;
  assign rdy[0]  = i0.Ready;
  assign rdy[1]  = i1.Ready;
  assign rdy[2]  = i2.Ready;
  assign rdy[3]  = i3.Ready;
  assign busy[0] = i0.Busy;
  assign busy[1] = i1.Busy;
  assign busy[2] = i2.Busy;
  assign busy[3] = i3.Busy;
  assign sent[0] = i0.charSent;
  assign sent[1] = i1.charSent;
  assign sent[2] = i2.charSent;
  assign sent[3] = i3.charSent;

  uart_tx_framer #(
    .CLK_DIV(4), .OVERSAMPLE(16), .DATA_BITS(8),
    .PARITY_MODE(0), .STOP_BITS(1)
  ) u0 (.CLOCK_50(clk), .reset(rst0), .bus(i0));

  uart_tx_framer #(
    .CLK_DIV(4), .OVERSAMPLE(16), .DATA_BITS(8),
    .PARITY_MODE(1), .STOP_BITS(1)
  ) u1 (.CLOCK_50(clk), .reset(rst_o), .bus(i1));

  uart_tx_framer #(
    .CLK_DIV(4), .OVERSAMPLE(16), .DATA_BITS(8),
    .PARITY_MODE(2), .STOP_BITS(1)
  ) u2 (.CLOCK_50(clk), .reset(rst_o), .bus(i2));

  uart_tx_framer #(
    .CLK_DIV(4), .OVERSAMPLE(16), .DATA_BITS(7),
    .PARITY_MODE(0), .STOP_BITS(2)
  ) u3 (.CLOCK_50(clk), .reset(rst_o), .bus(i3));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: sim time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag,
                     input logic [31:0] got,
                     input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%0h exp=%0h t=%0t",
               tag, got, exp, $time);
    end
  endtask

  // Sends one character on DUT s and checks every cycle of the
  // frame plus the first idle cycle after it.
  task automatic send_frame(input int s,
                            input logic [7:0] data,
                            input int nbits,
                            input int pmode,
                            input int nstop,
                            input bit hold,
                            input bit poke,
                            input logic [7:0] nxt);
    logic [12:0] fr;
    logic p;
    int nb;
    int fl;
    int b;
    p  = 1'b0;
    fr = '1;
    for (int i = 0; i < nbits; i++) p = p ^ data[i];
    if (pmode == 2) p = ~p;
    fr[0] = 1'b0;
    for (int i = 0; i < nbits; i++) fr[1+i] = data[i];
    nb = 1 + nbits;
    if (pmode != 0) begin
      fr[nb] = p;
      nb++;
    end
    for (int k = 0; k < nstop; k++) begin
      fr[nb] = 1'b1;
      nb++;
    end
    fl = nb * BIT;
    chk("ready_pre", rdy[s], 1);
    din     = data;
    load[s] = 1'b1;
    @(posedge clk);
    for (int n = 1; n <= fl + 1; n++) begin
      @(negedge clk);
      if (!hold && n == 1) load[s] = 1'b0;
      din = (n >= fl) ? nxt : ~din;
      if (poke && n == 100) begin
        load[s] = 1'b1;
        din     = 8'hFF;
      end
      if (poke && n == 101) load[s] = 1'b0;
      if (n <= fl) begin
        b = (n - 1) / BIT;
        chk("line", dout[s], fr[b]);
        chk("sent", sent[s], (n == fl));
        if (n == 1 || n == fl) begin
          chk("busy", busy[s], 1);
          chk("ready", rdy[s], 0);
        end
      end else begin
        chk("idle_line", dout[s], 1);
        chk("idle_ready", rdy[s], 1);
        chk("idle_busy", busy[s], 0);
        chk("idle_sent", sent[s], 0);
      end
    end
  endtask

  initial begin
    n_chk = 0;
    n_err = 0;
    rst0  = 1'b1;
    rst_o = 1'b1;
    din   = '0;
    load  = '0;
    repeat (3) @(negedge clk);
    for (int s = 0; s < 4; s++) begin
      chk("rst_line", dout[s], 1);
      chk("rst_ready", rdy[s], 1);
      chk("rst_busy", busy[s], 0);
      chk("rst_sent", sent[s], 0);
    end
    rst0  = 1'b0;
    rst_o = 1'b0;
    repeat (2) @(negedge clk);

    send_frame(0, 8'h55, 8, 0, 1, 0, 0, 8'h00);
    repeat (3) @(negedge clk);
    send_frame(1, 8'h07, 8, 1, 1, 0, 0, 8'h00);
    repeat (3) @(negedge clk);
    send_frame(2, 8'h07, 8, 2, 1, 0, 0, 8'h00);
    repeat (3) @(negedge clk);
    send_frame(3, 8'h7F, 7, 0, 2, 0, 0, 8'h00);
    repeat (3) @(negedge clk);
    send_frame(0, 8'h3C, 8, 0, 1, 0, 1, 8'h00);
    repeat (3) @(negedge clk);
    send_frame(0, 8'hA5, 8, 0, 1, 1, 0, 8'h3C);
    send_frame(0, 8'h3C, 8, 0, 1, 0, 0, 8'h00);
    repeat (3) @(negedge clk);

    din     = 8'h81;
    load[0] = 1'b1;
    @(posedge clk);
    for (int n = 1; n <= 300; n++) begin
      @(negedge clk);
      if (n == 1) load[0] = 1'b0;
    end
    chk("pre_rst_line", dout[0], 0);
    chk("pre_rst_busy", busy[0], 1);
    rst0 = 1'b1;
    #1;
    chk("arst_line", dout[0], 1);
    chk("arst_ready", rdy[0], 1);
    chk("arst_busy", busy[0], 0);
    chk("arst_sent", sent[0], 0);
    for (int n = 0; n < 3; n++) begin
      @(negedge clk);
      chk("rst_hold_sent", sent[0], 0);
      chk("rst_hold_line", dout[0], 1);
    end
    rst0 = 1'b0;
    @(negedge clk);
    send_frame(0, 8'h81, 8, 0, 1, 0, 0, 8'h00);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
